// File: rtl/pixseq_pkg.sv
// Shared definitions for the pixel readout sequencer: FSM state encoding and
// default parameter values.
package pixseq_pkg;

    localparam int unsigned INTEG_W_DEF    = 16;
    localparam int unsigned EVT_W_DEF      = 8;
    localparam int unsigned SETTLE_CYC_DEF = 4;
    localparam int unsigned TMO_CYC_DEF    = 255;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StPrst   = 4'd1,
        StPwait  = 4'd2,
        StInteg  = 4'd3,
        StRdclr  = 4'd4,
        StSettle = 4'd5,
        StSamp   = 4'd6,
        StMstep  = 4'd7,
        StMwait  = 4'd8,
        StEvtend = 4'd9
    } state_e;

endpackage

// File: rtl/pixel_readout_seq_if.sv
// Control/handshake bundle between the sequencer (master) and the run
// controller plus pixel block (slave).
interface pixel_readout_seq_if #(
    parameter int unsigned INTEG_W = 16,
    parameter int unsigned EVT_W   = 8
);
    // Run control
    logic               start;
    logic               stop;
    logic               trg_mode;
    logic               trg_in;
    logic [INTEG_W-1:0] integ_cyc;
    logic [EVT_W-1:0]   evt_num;
    // Pixel block / ADC responses
    logic               pix_end_i;
    logic               mem_set_done_i;
    logic               last_mem_i;
    logic               sample_ack;
    // Sequencer outputs
    logic               pix_reset_o;
    logic               pix_store_o;
    logic               mem_set_en_o;
    logic               mem_set_clr_o;
    logic               sample_req;
    logic               busy;
    logic               evt_num_end;
    logic [EVT_W-1:0]   evt_cnt;
    logic               err_tmo;

    modport master (
        input  start, stop, trg_mode, trg_in, integ_cyc, evt_num,
        input  pix_end_i, mem_set_done_i, last_mem_i, sample_ack,
        output pix_reset_o, pix_store_o, mem_set_en_o, mem_set_clr_o, sample_req,
        output busy, evt_num_end, evt_cnt, err_tmo
    );

    modport slave (
        output start, stop, trg_mode, trg_in, integ_cyc, evt_num,
        output pix_end_i, mem_set_done_i, last_mem_i, sample_ack,
        input  pix_reset_o, pix_store_o, mem_set_en_o, mem_set_clr_o, sample_req,
        input  busy, evt_num_end, evt_cnt, err_tmo
    );

endinterface

// File: rtl/pixseq_timer.sv
// Loadable down-counter with zero flag. Saturates at zero so a state can
// wait on the flag indefinitely after expiry.
module pixseq_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pixel_readout_seq.sv
// Frame sequencer for one pixel-control block: pixel reset, integration,
// memory readout and ADC sampling per event, repeated for a run.
// Optional build macro PIXSEQ_TRG_VETO_EN: in trigger mode, triggers during the
// first SETTLE_CYC cycles of integration are ignored.
module pixel_readout_seq
    import pixseq_pkg::*;
#(
    parameter int unsigned INTEG_W    = INTEG_W_DEF,
    parameter int unsigned EVT_W      = EVT_W_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned TMO_CYC    = TMO_CYC_DEF
) (
    input logic                 clk,
    input logic                 rst,
    pixel_readout_seq_if.master bus
);

    // One timer serves integration, settle and watchdog; wide enough for all.
    localparam int unsigned TMR_W = (INTEG_W > 8) ? INTEG_W : 8;

    state_e             r_state;
    state_e             w_state_d;
    logic [INTEG_W-1:0] r_integ_cyc;
    logic [EVT_W-1:0]   r_evt_num;
    logic [EVT_W-1:0]   r_evt_cnt;
    logic [EVT_W-1:0]   w_cnt_inc;
    logic               r_evt_num_end;
    logic               r_err_tmo;
    logic               r_stop_pend;
    logic               w_evt_done;
    logic               w_timeout;
    logic               w_trg_ok;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_zero;

    pixseq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_val  (w_tmr_val),
        .o_zero (w_tmr_zero)
    );

    assign w_cnt_inc  = r_evt_cnt + EVT_W'(1);
    assign w_evt_done = (r_evt_num != '0) && (w_cnt_inc == r_evt_num);

`ifdef PIXSEQ_TRG_VETO_EN
    // Timer runs the veto window on INTEG entry; trigger counts once it expires
    assign w_trg_ok = bus.trg_in && w_tmr_zero;
`else
    assign w_trg_ok = bus.trg_in;
`endif

    // Next-state decode
    always_comb begin
        w_state_d = r_state;
        w_timeout = 1'b0;
        unique case (r_state)
            StIdle:   if (bus.start) w_state_d = StPrst;
            StPrst:   w_state_d = StPwait;
            StPwait: begin
                if (bus.pix_end_i) begin
                    w_state_d = StInteg;
                end else if (w_tmr_zero) begin
                    w_state_d = StIdle;
                    w_timeout = 1'b1;
                end
            end
            StInteg: begin
                if (bus.trg_mode ? w_trg_ok : w_tmr_zero) w_state_d = StRdclr;
            end
            StRdclr:  w_state_d = StSettle;
            StSettle: if (w_tmr_zero) w_state_d = StSamp;
            StSamp: begin
                if (bus.sample_ack) w_state_d = bus.last_mem_i ? StEvtend : StMstep;
            end
            StMstep:  w_state_d = StMwait;
            StMwait: begin
                if (bus.mem_set_done_i) begin
                    w_state_d = StSettle;
                end else if (w_tmr_zero) begin
                    w_state_d = StIdle;
                    w_timeout = 1'b1;
                end
            end
            StEvtend: begin
                if (w_evt_done || r_stop_pend || bus.stop) w_state_d = StIdle;
                else w_state_d = StPrst;
            end
            default:  w_state_d = StIdle;
        endcase
    end

    // Timer reload on every state change, with the budget of the state entered
    always_comb begin
        w_tmr_load = (w_state_d != r_state);
        w_tmr_val  = '0;
        case (w_state_d)
            StPwait, StMwait: w_tmr_val = TMR_W'(TMO_CYC);
            StSettle:         w_tmr_val = TMR_W'(SETTLE_CYC - 1);
            StInteg: begin
                if (bus.trg_mode) begin
`ifdef PIXSEQ_TRG_VETO_EN
                    w_tmr_val = TMR_W'(SETTLE_CYC);
`else
                    w_tmr_val = '0;
`endif
                end else if (r_integ_cyc != '0) begin
                    // Exit on the zero cycle, so INTEG lasts exactly INTEG_CYC cycles
                    w_tmr_val = TMR_W'(r_integ_cyc) - TMR_W'(1);
                end
            end
            default:          w_tmr_val = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    // Run configuration, event counter, stop latch and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_integ_cyc   <= '0;
            r_evt_num     <= '0;
            r_evt_cnt     <= '0;
            r_evt_num_end <= 1'b0;
            r_err_tmo     <= 1'b0;
            r_stop_pend   <= 1'b0;
        end else begin
            if (r_state == StIdle) begin
                r_stop_pend <= 1'b0;
                if (bus.start) begin
                    r_integ_cyc   <= bus.integ_cyc;
                    r_evt_num     <= bus.evt_num;
                    r_evt_cnt     <= '0;
                    r_evt_num_end <= 1'b0;
                    r_err_tmo     <= 1'b0;
                end
            end else if (bus.stop) begin
                r_stop_pend <= 1'b1;
            end
            if (r_state == StEvtend) begin
                r_evt_cnt <= w_cnt_inc;
                if (w_evt_done) r_evt_num_end <= 1'b1;
            end
            if (w_timeout) r_err_tmo <= 1'b1;
        end
    end

    // Moore outputs: every strobe is a pure state decode, so reset clears them at once
    always_comb begin
        bus.pix_reset_o   = (r_state == StPrst);
        bus.pix_store_o   = (r_state == StPrst) || (r_state == StPwait) ||
                            (r_state == StInteg);
        bus.mem_set_clr_o = (r_state == StRdclr);
        bus.mem_set_en_o  = (r_state == StMstep);
        bus.sample_req    = (r_state == StSamp);
        bus.busy          = (r_state != StIdle);
        bus.evt_num_end   = r_evt_num_end;
        bus.evt_cnt       = r_evt_cnt;
        bus.err_tmo       = r_err_tmo;
    end

endmodule

// File: tb/tb_pixel_readout_seq.sv
// Self-checking bench for pixel_readout_seq with a behavioural pixel/ADC model.
module tb_pixel_readout_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_readout_seq_if #(.INTEG_W(16), .EVT_W(8)) bus ();

    pixel_readout_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pixel / ADC model configuration (written by the main sequence only)
    int read_mem    = 2;
    int ack_dly     = 3;
    int pe_dly      = 2;
    int md_dly      = 1;
    bit pe_withhold = 1'b0;

    // Observation counters (written by the model block only)
    int n_prst = 0, n_clr = 0, n_step = 0, n_req = 0, n_pwait = 0;
    int n_lat_bad = 0, n_wrap = 0, last_integ = 0;

    // Model internals
    int pe_cnt = 0, md_cnt = 0, sa_cnt = 0, mem_cnt = 0, integ_len = 0;
    bit prev_en = 0, prev_req = 0, integ_on = 0, ack_nl_q = 0;
    int prev_cnt = 0;

    int n_total = 0;
    int n_bad   = 0;

    // Pixel block, ADC and output monitor; everything happens on the falling edge
    always @(negedge clk) begin
        bus.pix_end_i      = 1'b0;
        bus.mem_set_done_i = 1'b0;
        bus.sample_ack     = 1'b0;
        if (rst) begin
            pe_cnt = 0; md_cnt = 0; sa_cnt = 0; mem_cnt = 0;
            prev_en = 0; prev_req = 0; integ_on = 0; ack_nl_q = 0;
            bus.last_mem_i = 1'b0;
        end else begin
            if (bus.pix_reset_o) begin
                n_prst++;
                pe_cnt = pe_withhold ? 0 : pe_dly;
            end else if (pe_cnt != 0) begin
                pe_cnt--;
                if (pe_cnt == 0) bus.pix_end_i = 1'b1;
            end
            if (bus.mem_set_clr_o) begin
                n_clr++;
                mem_cnt = 0;
            end
            if (ack_nl_q && !bus.mem_set_en_o) n_lat_bad++;
            if (bus.mem_set_en_o && !prev_en) begin
                n_step++;
                mem_cnt++;
                md_cnt = md_dly;
            end else if (md_cnt != 0) begin
                md_cnt--;
                if (md_cnt == 0) bus.mem_set_done_i = 1'b1;
            end
            bus.last_mem_i = (mem_cnt >= read_mem - 1);
            if (bus.sample_req && !prev_req) begin
                n_req++;
                sa_cnt = ack_dly;
            end else if (sa_cnt != 0) begin
                sa_cnt--;
                if (sa_cnt == 0 && bus.sample_req) bus.sample_ack = 1'b1;
            end
            ack_nl_q = bus.sample_ack && !bus.last_mem_i;
            if (bus.pix_store_o && !bus.pix_reset_o && !integ_on) n_pwait++;
            if (integ_on && bus.pix_store_o) begin
                integ_len++;
            end else if (integ_on) begin
                integ_on   = 0;
                last_integ = integ_len;
            end
            if (bus.pix_end_i) begin
                integ_on  = 1;
                integ_len = 0;
            end
            if (prev_cnt == 255 && bus.evt_cnt == 8'd0 && bus.busy) n_wrap++;
        end
        prev_en  = bus.mem_set_en_o;
        prev_req = bus.sample_req;
        prev_cnt = int'(bus.evt_cnt);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while (bus.busy === 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_pix_end(input int max_cyc);
        int k = 0;
        while (bus.pix_end_i !== 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_prst(input int target, input int max_cyc);
        int k = 0;
        while (n_prst < target && k < max_cyc) begin
            tick();
            k++;
        end
    endtask

    task automatic all_outputs_zero(input string tag);
        chk({tag, "_strobes"}, int'({bus.pix_reset_o, bus.pix_store_o, bus.mem_set_en_o,
            bus.mem_set_clr_o, bus.sample_req, bus.busy}), 0);
        chk({tag, "_evt_cnt"}, int'(bus.evt_cnt), 0);
    endtask

    int b_prst, b_clr, b_step, b_req, b_pwait, b_lat, b_wrap;
    int e_num, i_cyc, exp_integ;

    task automatic snap();
        b_prst = n_prst; b_clr = n_clr; b_step = n_step; b_req = n_req;
        b_pwait = n_pwait; b_lat = n_lat_bad; b_wrap = n_wrap;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.trg_mode = 0; bus.trg_in = 0;
        bus.integ_cyc = '0; bus.evt_num = '0;
        repeat (3) tick();
        all_outputs_zero("reset");
        chk("reset_end", int'(bus.evt_num_end), 0);
        chk("reset_err", int'(bus.err_tmo), 0);
        rst = 1'b0;
        tick();

        // T1: timed integration, one event, two memories
        read_mem = 2; ack_dly = 3; pe_dly = 2; md_dly = 1;
        bus.integ_cyc = 16'd10; bus.evt_num = 8'd1;
        snap();
        pulse_start();
        chk("t1_start_latency", int'({bus.pix_reset_o, bus.pix_store_o, bus.busy}), 7);
        wait_idle(2000);
        chk("t1_idle", int'(bus.busy), 0);
        chk("t1_prst", n_prst - b_prst, 1);
        chk("t1_integ", last_integ, 10);
        chk("t1_clr", n_clr - b_clr, 1);
        chk("t1_step", n_step - b_step, 1);
        chk("t1_req", n_req - b_req, 2);
        chk("t1_ack_latency", n_lat_bad - b_lat, 0);
        chk("t1_evt_cnt", int'(bus.evt_cnt), 1);
        chk("t1_evt_end", int'(bus.evt_num_end), 1);

        // Randomised runs against count rules derived from the event structure
        for (int r = 0; r < 5; r++) begin
            read_mem = int'($urandom_range(1, 5));
            ack_dly  = int'($urandom_range(1, 4));
            pe_dly   = int'($urandom_range(1, 6));
            md_dly   = int'($urandom_range(1, 4));
            i_cyc    = int'($urandom_range(0, 20));
            e_num    = int'($urandom_range(1, 3));
            bus.integ_cyc = 16'(i_cyc); bus.evt_num = 8'(e_num);
            exp_integ = (i_cyc == 0) ? 1 : i_cyc;
            snap();
            pulse_start();
            bus.integ_cyc = 16'hffff; // latched at START; later changes must not matter
            wait_idle(5000);
            chk("rnd_idle", int'(bus.busy), 0);
            chk("rnd_prst", n_prst - b_prst, e_num);
            chk("rnd_clr", n_clr - b_clr, e_num);
            chk("rnd_step", n_step - b_step, e_num * (read_mem - 1));
            chk("rnd_req", n_req - b_req, e_num * read_mem);
            chk("rnd_integ", last_integ, exp_integ);
            chk("rnd_ack_latency", n_lat_bad - b_lat, 0);
            chk("rnd_evt_cnt", int'(bus.evt_cnt), e_num);
            chk("rnd_evt_end", int'(bus.evt_num_end), 1);
        end

        // T2: STOP during the second event's integration
        read_mem = 2; ack_dly = 2; pe_dly = 2; md_dly = 1;
        bus.integ_cyc = 16'd8; bus.evt_num = 8'd3;
        snap();
        pulse_start();
        wait_prst(b_prst + 2, 2000);
        wait_pix_end(100);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_idle(2000);
        chk("t2_idle", int'(bus.busy), 0);
        chk("t2_evt_cnt", int'(bus.evt_cnt), 2);
        chk("t2_evt_end", int'(bus.evt_num_end), 0);
        chk("t2_req", n_req - b_req, 4);

        // T3: trigger-gated integration
        read_mem = 1;
        bus.trg_mode = 1'b1; bus.integ_cyc = 16'd0; bus.evt_num = 8'd1;
        pulse_start();
        wait_pix_end(100);
`ifdef PIXSEQ_TRG_VETO_EN
        repeat (2) tick();
        bus.trg_in = 1'b1;
        tick();
        bus.trg_in = 1'b0;
        chk("t3_veto_hold", int'({bus.pix_store_o, bus.mem_set_clr_o}), 2);
        repeat (47) tick();
`else
        repeat (50) tick();
`endif
        chk("t3_still_integ", int'({bus.pix_store_o, bus.mem_set_clr_o}), 2);
        bus.trg_in = 1'b1;
        tick();
        bus.trg_in = 1'b0;
        chk("t3_rdclr", int'({bus.pix_store_o, bus.mem_set_clr_o}), 1);
        wait_idle(500);
        chk("t3_integ", last_integ, 51);
        chk("t3_evt_cnt", int'(bus.evt_cnt), 1);
        bus.trg_mode = 1'b0;

        // T4: PIX_END_I withheld -> watchdog
        pe_withhold = 1'b1;
        bus.integ_cyc = 16'd5; bus.evt_num = 8'd1;
        snap();
        pulse_start();
        for (int k = 0; k < 1000 && bus.err_tmo !== 1'b1; k++) tick();
        chk("t4_err", int'(bus.err_tmo), 1);
        chk("t4_pwait_len", n_pwait - b_pwait, 256);
        chk("t4_outputs", int'({bus.pix_reset_o, bus.pix_store_o, bus.mem_set_en_o,
            bus.mem_set_clr_o, bus.sample_req, bus.busy}), 0);
        pe_withhold = 1'b0;
        pulse_start();
        chk("t4_err_clear", int'({bus.err_tmo, bus.busy}), 1);
        wait_idle(2000);
        chk("t4_rerun_evt_cnt", int'(bus.evt_cnt), 1);

        // T5: reset during SAMP of the second event
        read_mem = 3; ack_dly = 8;
        bus.evt_num = 8'd3;
        snap();
        pulse_start();
        wait_prst(b_prst + 2, 2000);
        for (int k = 0; k < 500 && bus.sample_req !== 1'b1; k++) tick();
        chk("t5_in_samp", int'({bus.sample_req, bus.evt_cnt}), 257);
        rst = 1'b1;
        #1;
        all_outputs_zero("t5");
        chk("t5_flags", int'({bus.evt_num_end, bus.err_tmo}), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_stay_idle", int'(bus.busy), 0);

        // T6: unlimited run, counter wrap, stop after 300 events
        read_mem = 4; ack_dly = 1; pe_dly = 1; md_dly = 1;
        bus.integ_cyc = 16'd0; bus.evt_num = 8'd0;
        snap();
        pulse_start();
        wait_prst(b_prst + 300, 30000);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_idle(500);
        chk("t6_idle", int'(bus.busy), 0);
        chk("t6_events", n_prst - b_prst, 300);
        chk("t6_evt_cnt", int'(bus.evt_cnt), 300 % 256);
        chk("t6_wrap", n_wrap - b_wrap, 1);
        chk("t6_step", n_step - b_step, 300 * 3);
        chk("t6_req", n_req - b_req, 300 * 4);
        chk("t6_evt_end", int'(bus.evt_num_end), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
